bram_frame_writer: RTL and testbench
====================================

BRAM_FRAME_WRITER -- requirements
Module: bram_frame_writer

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 4, meaning the data word width in bits.
REQ-002 SHALL have parameter RAM_DEPTH, default 1024, meaning the number of memory words.
REQ-003 SHALL have parameter FRAME_LEN, default 1024, meaning the words per frame; legal range is 1..RAM_DEPTH.
REQ-004 SHALL define AW = $clog2(RAM_DEPTH).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: a pulse that begins capture of a new frame.
REQ-008 SHALL have port in_valid, input, 1 bit: the producer has a word on in_data.
REQ-009 SHALL have port in_data, input, RAM_WIDTH bits: the incoming pixel word.
REQ-010 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-011 SHALL have port rd_addr, input, AW bits: the consumer read address.
REQ-012 SHALL have port rd_data, output, RAM_WIDTH bits: registered read data.
REQ-013 SHALL have port wr_count, output, AW+1 bits: the number of words written in the current frame.
REQ-014 SHALL have port busy, output, 1 bit: high while in FILL.
REQ-015 SHALL have port done, output, 1 bit: a one-cycle pulse when the frame completes.
REQ-016 SHALL have port frame_ready, output, 1 bit: a level meaning the memory holds a complete frame.

Function
REQ-017 SHALL contain a simple dual-port memory of RAM_DEPTH x RAM_WIDTH bits, mapped to block RAM, with one write port and one read port.
REQ-018 SHALL implement the FSM states IDLE, FILL and COMPLETE.
REQ-019 SHALL leave IDLE or COMPLETE for FILL when start=1, with wr_count cleared to 0 and frame_ready cleared to 0 on that edge.
REQ-020 SHALL drive in_ready=1 only in FILL, decoded from registered state only, with no combinational path from in_valid or start.
REQ-021 SHALL count a word as accepted only when in_valid=1 and in_ready=1 on the same edge; the accepted word is written to mem[wr_count[AW-1:0]] and wr_count increments by 1.
REQ-022 SHALL, on acceptance of word number FRAME_LEN (wr_count going from FRAME_LEN-1 to FRAME_LEN), move the FSM to COMPLETE, drive done=1 for exactly the next cycle and set frame_ready=1.
REQ-023 SHALL hold wr_count, memory contents and frame_ready=1 in COMPLETE until the next start or reset.
REQ-024 SHALL ignore start in FILL: no restart, and no change to wr_count.
REQ-025 SHALL treat in_valid=0 in FILL as a stall: no write, no count change, no timeout.
REQ-026 SHALL register read data with 1-cycle latency: rd_data at edge N+1 equals mem[rd_addr sampled at edge N].
REQ-027 SHALL allow reads in every state.
REQ-028 SHALL return the old memory content for a read and write to the same address on the same edge (read-first).
REQ-029 SHALL ensure wr_count never exceeds FRAME_LEN and that the write address never wraps within a frame.
REQ-030 SHALL, for FRAME_LEN=1, complete on the single accepted word, with done asserted on the following cycle.
REQ-031 SHALL accept back-to-back words every cycle while in_valid is held high, giving a throughput of 1 word per clock.

Reset
REQ-032 SHALL, when rst=1, immediately and asynchronously force: state=IDLE, in_ready=0, busy=0, done=0, frame_ready=0, wr_count=0, rd_data=0.
REQ-033 SHALL NOT clear memory contents on reset.
REQ-034 SHALL, on reset asserted mid-FILL, abort the frame: frame_ready stays 0 and a new start is required.
REQ-035 SHALL, after rst deasserts, ignore start only in the first cycle.

Verification
REQ-036 SHALL cover: FRAME_LEN=16, start, then 16 words 0..15 at in_valid=1 continuously -> in_ready high for 16 cycles; done pulses once on the cycle after the 16th acceptance; frame_ready=1; wr_count=16; reads of addresses 0..15 return 0..15 with 1-cycle latency.
REQ-037 SHALL cover: FRAME_LEN=16 with in_valid toggling 1,0,1,0 -> exactly 16 writes; wr_count increments only on handshake edges; done follows the 16th accepted word.
REQ-038 SHALL cover: start pulsed at word 5 during FILL -> ignored; wr_count continues 6,7,...; the frame completes normally.
REQ-039 SHALL cover: rst asserted after 8 accepted words -> all outputs 0 asynchronously, before the next edge; a new start and 16 words then give frame_ready=1.
REQ-040 SHALL cover: write 0xA to address 3 while rd_addr=3 on the same edge, old value 0x5 -> rd_data=0x5, then 0xA on the next read.
REQ-041 SHALL cover: FRAME_LEN=1, start, one word 0x7 -> done on the next cycle; mem[0]=0x7; in_ready=0 thereafter.

Source files
------------

// File: rtl/bram_frame_writer.sv
`timescale 1ns/1ps
// Captures one frame of pixel words into a simple dual-port block RAM and
// exposes a registered read port for the consumer, usable in every state.
module bram_frame_writer #(
    parameter int RAM_WIDTH = 4,
    parameter int RAM_DEPTH = 1024,
    parameter int FRAME_LEN = 1024,
    localparam int AW = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [RAM_WIDTH-1:0] in_data,
    output logic                 in_ready,
    input  logic [AW-1:0]        rd_addr,
    output logic [RAM_WIDTH-1:0] rd_data,
    output logic [AW:0]          wr_count,
    output logic                 busy,
    output logic                 done,
    output logic                 frame_ready
);

    typedef enum logic [1:0] {IDLE, FILL, COMPLETE} state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(FRAME_LEN - 1);

    state_t state, state_nxt;
    logic   armed;
    logic   accept;
    logic   last_word;
    logic   start_ok;

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Handshake signals come only from registered state: no in_valid/start path to in_ready.
    assign in_ready  = (state == FILL);
    assign busy      = (state == FILL);
    assign accept    = in_valid && in_ready;
    assign last_word = accept && (wr_count == LAST_IDX);
    // armed blocks a start in the very first cycle after reset release.
    assign start_ok  = start && armed && (state != FILL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok)  state_nxt = FILL;
            FILL:     if (last_word) state_nxt = COMPLETE;
            COMPLETE: if (start_ok)  state_nxt = FILL;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count    <= '0;
            done        <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            done <= last_word;
            if (start_ok) begin
                wr_count    <= '0;
                frame_ready <= 1'b0;
            end else if (accept) begin
                wr_count <= wr_count + 1'b1;
                if (last_word) frame_ready <= 1'b1;
            end
        end
    end

    // Memory array is never reset so it maps onto block RAM; read-first on collisions.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_count[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_bram_frame_writer.sv
`timescale 1ns/1ps
// Scoreboard bench for bram_frame_writer: a 16-word frame instance and a
// single-word frame instance share clock and reset.
module tb_bram_frame_writer;

    localparam int W     = 4;
    localparam int DEPTH = 32;
    localparam int FLEN  = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, in_valid, in_ready, busy, done, frame_ready;
    logic [W-1:0]  in_data, rd_data;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   wr_count;

    logic          start_s, in_valid_s, in_ready_s, busy_s, done_s, frame_ready_s;
    logic [W-1:0]  in_data_s, rd_data_s;
    logic [1:0]    rd_addr_s;
    logic [2:0]    wr_count_s;

    bram_frame_writer #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .FRAME_LEN(FLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count),
        .busy(busy), .done(done), .frame_ready(frame_ready)
    );

    bram_frame_writer #(.RAM_WIDTH(W), .RAM_DEPTH(4), .FRAME_LEN(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid_s), .in_data(in_data_s),
        .in_ready(in_ready_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s), .wr_count(wr_count_s),
        .busy(busy_s), .done(done_s), .frame_ready(frame_ready_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_mem [DEPTH];
    logic [W-1:0] rd_q [$];
    int           exp_wc;
    bit           exp_fill, exp_fr, exp_done, exp_armed, rd_en;
    int           done_seen, ready_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock: update the reference model from the inputs, then compare.
    task automatic tick();
        bit acc;
        if (rd_en) rd_q.push_back(exp_mem[rd_addr]);
        acc      = in_valid && exp_fill;
        exp_done = 1'b0;
        if (acc) begin
            exp_mem[exp_wc] = in_data;
            exp_wc++;
            if (exp_wc == FLEN) begin
                exp_done = 1'b1;
                exp_fill = 1'b0;
                exp_fr   = 1'b1;
            end
        end else if (start && exp_armed && !exp_fill) begin
            exp_fill = 1'b1;
            exp_wc   = 0;
            exp_fr   = 1'b0;
        end
        exp_armed = 1'b1;
        @(posedge clk);
        #1;
        check("wr_count", wr_count, exp_wc);
        check("in_ready", in_ready, exp_fill);
        check("busy", busy, exp_fill);
        check("done", done, exp_done);
        check("frame_ready", frame_ready, exp_fr);
        if (done) done_seen++;
        if (in_ready) ready_seen++;
        if (rd_en) check("rd_data", rd_data, rd_q.pop_front());
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic read_frame(input int n);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            rd_addr = AW'(i);
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_data", rd_data, 0);
        exp_fill  = 1'b0;
        exp_wc    = 0;
        exp_fr    = 1'b0;
        exp_done  = 1'b0;
        exp_armed = 1'b0;
        #2 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_addr = '0; rd_en = 1'b0;
        start_s = 1'b0; in_valid_s = 1'b0; in_data_s = '0; rd_addr_s = '0;
        exp_wc = 0; exp_fill = 1'b0; exp_fr = 1'b0; exp_done = 1'b0; exp_armed = 1'b0;
        done_seen = 0; ready_seen = 0;
        #3;
        check("init_in_ready", in_ready, 0);
        check("init_wr_count", wr_count, 0);
        check("init_frame_ready", frame_ready, 0);
        check("init_rd_data", rd_data, 0);
        #4 rst = 1'b0;

        // start in the first cycle after reset release is ignored
        do_start();
        tick();

        // continuous 16-word frame
        done_seen = 0; ready_seen = 0;
        do_start();
        in_valid = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            in_data = W'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t1_done_pulses", done_seen, 1);
        check("t1_ready_cycles", ready_seen, 16);
        check("t1_wr_count", wr_count, 16);
        read_frame(FLEN);

        // toggling in_valid: stalls must not write or count
        done_seen = 0;
        do_start();
        for (int i = 0; i < FLEN; i++) begin
            in_valid = 1'b1; in_data = W'(15 - i);
            tick();
            in_valid = 1'b0; in_data = 4'hF;
            tick();
        end
        check("t2_done_pulses", done_seen, 1);
        read_frame(FLEN);

        // start pulsed mid-frame is ignored
        done_seen = 0;
        do_start();
        in_valid = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            in_data = (i == 3) ? 4'h5 : W'(i + 1);
            start   = (i == 5);
            tick();
        end
        start = 1'b0; in_valid = 1'b0;
        check("t3_done_pulses", done_seen, 1);
        read_frame(FLEN);

        // read-first collision at address 3
        do_start();
        in_valid = 1'b1;
        rd_addr  = 5'd3;
        for (int i = 0; i < FLEN; i++) begin
            in_data = (i == 3) ? 4'hA : W'(i * 3);
            rd_en   = (i == 3) || (i == 4);
            tick();
            if (i == 3) check("rf_old", rd_data, 4'h5);
            if (i == 4) check("rf_new", rd_data, 4'hA);
        end
        in_valid = 1'b0; rd_en = 1'b0;

        // reset after 8 words aborts the frame; memory survives
        do_start();
        in_valid = 1'b1; rd_en = 1'b1; rd_addr = 5'd5;
        for (int i = 0; i < 8; i++) begin
            in_data = W'(i + 9);
            tick();
        end
        in_valid = 1'b0; rd_en = 1'b0;
        mid_reset();
        do_start();
        tick();
        read_frame(12);
        do_start();
        in_valid = 1'b1;
        for (int i = 0; i < FLEN; i++) begin
            in_data = W'(i ^ 6);
            tick();
        end
        in_valid = 1'b0;
        check("t5_frame_ready", frame_ready, 1);

        // COMPLETE holds count and memory despite in_valid
        in_valid = 1'b1; in_data = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        in_valid = 1'b0;
        read_frame(FLEN);

        // single-word frame instance
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        check("s_ready", in_ready_s, 1);
        in_valid_s = 1'b1; in_data_s = 4'h7;
        @(posedge clk); #1;
        in_valid_s = 1'b0; in_data_s = 4'h0;
        check("s_done", done_s, 1);
        check("s_wr_count", wr_count_s, 1);
        check("s_frame_ready", frame_ready_s, 1);
        check("s_ready_after", in_ready_s, 0);
        rd_addr_s = 2'd0;
        @(posedge clk); #1;
        check("s_done_clear", done_s, 0);
        check("s_ready_hold", in_ready_s, 0);
        check("s_mem0", rd_data_s, 4'h7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
